// File: rtl/seq_tag_pkg.sv
// Shared types and default window constants for the tagged request/grant/command/completion controller.
package seq_tag_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    ARM,
    CMD,
    WAIT_D
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_B_TIMEOUT = 2'd1,
    ERR_D_EARLY   = 2'd2,
    ERR_D_TIMEOUT = 2'd3
  } err_code_e;

  localparam int B_MAX_DEF = 5;
  localparam int D_MIN_DEF = 2;
  localparam int D_MAX_DEF = 10;
  localparam int TAG_W_DEF = 8;

  // Counter width able to hold max_cnt; never narrower than one bit.
  function automatic int cnt_width(input int max_cnt);
    int w;
    w = $clog2(max_cnt + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_win_timer.sv
// Cycle counter shared by the grant and completion windows; lo/hi select which window is being timed.
module seq_win_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] lo_i,
  input  logic [CNT_W-1:0] hi_i,
  output logic             early_o,
  output logic             in_win_o,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Load makes the current cycle number 0; the flags describe the count now.
  assign early_o   = (cnt_q < lo_i);
  assign in_win_o  = (cnt_q >= lo_i) && (cnt_q <= hi_i);
  assign expired_o = (cnt_q == hi_i);

endmodule

// File: rtl/seq_tag_ctrl.sv
// Transaction controller: raises a, waits for grant b, pulses c, waits for completion d,
// and keeps granted/retired tag counts.
module seq_tag_ctrl import seq_tag_pkg::*; #(
  parameter int B_MAX = B_MAX_DEF,
  parameter int D_MIN = D_MIN_DEF,
  parameter int D_MAX = D_MAX_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             req_rdy,
  output logic             a,
  input  logic             b,
  output logic             c,
  input  logic             d,
  output logic             done,
  output logic [TAG_W-1:0] done_tag,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [TAG_W-1:0] an_tag,
  output logic [TAG_W-1:0] co_tag
);

  localparam int CNT_W = cnt_width((B_MAX > D_MAX) ? B_MAX : D_MAX);

  state_e           state_q;
  logic             a_q, c_q, done_q, err_q;
  err_code_e        err_code_q;
  logic [TAG_W-1:0] done_tag_q, an_q, co_q;

  logic             tmr_load, tmr_en;
  logic [CNT_W-1:0] win_lo, win_hi;
  logic             early, in_win, expired;

  // In ARM the timer measures the grant window, otherwise the completion window.
  assign win_lo   = (state_q == ARM) ? CNT_W'(1)     : CNT_W'(D_MIN);
  assign win_hi   = (state_q == ARM) ? CNT_W'(B_MAX) : CNT_W'(D_MAX);
  assign tmr_load = ((state_q == IDLE) && req) || ((state_q == ARM) && b && in_win);
  assign tmr_en   = (state_q == ARM) || (state_q == CMD) || (state_q == WAIT_D);

  seq_win_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .en_i      (tmr_en),
    .lo_i      (win_lo),
    .hi_i      (win_hi),
    .early_o   (early),
    .in_win_o  (in_win),
    .expired_o (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= 1'b0;
      c_q        <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      done_tag_q <= '0;
      an_q       <= '0;
      co_q       <= '0;
    end else begin
      c_q        <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= ARM;
            a_q     <= 1'b1;
          end
        end
        ARM: begin
          // A grant on the final window cycle beats the timeout.
          if (b && in_win) begin
            an_q    <= an_q + TAG_W'(1);
            a_q     <= 1'b0;
            c_q     <= 1'b1;
            state_q <= CMD;
          end else if (expired) begin
            a_q        <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= ERR_B_TIMEOUT;
            state_q    <= GAP;
          end
        end
        CMD, WAIT_D: begin
          if (d && early) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_D_EARLY;
            co_q       <= co_q + TAG_W'(1);
            state_q    <= GAP;
          end else if (d && in_win) begin
            done_q     <= 1'b1;
            done_tag_q <= co_q;
            co_q       <= co_q + TAG_W'(1);
            state_q    <= GAP;
          end else if (expired) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_D_TIMEOUT;
            co_q       <= co_q + TAG_W'(1);
            state_q    <= GAP;
          end else begin
            state_q <= WAIT_D;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_rdy  = (state_q == IDLE);
  assign a        = a_q;
  assign c        = c_q;
  assign done     = done_q;
  assign done_tag = done_tag_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign an_tag   = an_q;
  assign co_tag   = co_q;

endmodule

// File: tb/tb_seq_tag_ctrl.sv
// Scoreboard bench for seq_tag_ctrl: stimulus queues expected events and probes, a negedge monitor checks them.
module tb_seq_tag_ctrl;

  localparam int B_MAX = 5;
  localparam int D_MIN = 2;
  localparam int D_MAX = 10;
  localparam int TAG_W = 8;

  logic clk = 1'b0;
  logic rst, req, b, d;
  logic req_rdy, a, c, done, err;
  logic [TAG_W-1:0] done_tag, an_tag, co_tag;
  logic [1:0] err_code;

  seq_tag_ctrl #(.B_MAX(B_MAX), .D_MIN(D_MIN), .D_MAX(D_MAX), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_rdy  (req_rdy),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .done     (done),
    .done_tag (done_tag),
    .err      (err),
    .err_code (err_code),
    .an_tag   (an_tag),
    .co_tag   (co_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [1:0] code;
    logic [7:0] tag;
    logic [7:0] an;
    logic [7:0] co;
  } ev_t;

  typedef struct {
    int         cyc;
    logic       a, c, rdy;
    logic [7:0] an, co, dt;
  } pr_t;

  ev_t evq[$];
  pr_t prq[$];
  int  n_vec  = 0;
  int  n_miss = 0;
  bit  fin    = 1'b0;

  logic [7:0] exp_an = 8'd0;
  logic [7:0] exp_co = 8'd0;
  logic [7:0] exp_dt = 8'd0;

  // Monitor: every done/err pulse must match the head of the event queue;
  // probes check the quiet outputs on a chosen cycle.
  always @(negedge clk) begin : mon
    ev_t e;
    pr_t p;
    if (done || err) begin
      n_vec++;
      if (evq.size() == 0) begin
        n_miss++;
        $display("FAIL event: unexpected pulse at cyc=%0d done=%b err=%b code=%0d, required no pulse",
                 cyc, done, err, err_code);
      end else begin
        e = evq.pop_front();
        if ((e.cyc != cyc) || (done !== !e.is_err) || (err !== e.is_err) ||
            (err_code !== (e.is_err ? e.code : 2'd0)) ||
            (!e.is_err && (done_tag !== e.tag)) ||
            (an_tag !== e.an) || (co_tag !== e.co)) begin
          n_miss++;
          $display("FAIL event: got cyc=%0d done=%b err=%b code=%0d tag=%0d an=%0d co=%0d, required cyc=%0d err=%b code=%0d tag=%0d an=%0d co=%0d",
                   cyc, done, err, err_code, done_tag, an_tag, co_tag,
                   e.cyc, e.is_err, e.code, e.tag, e.an, e.co);
        end
      end
    end
    while (prq.size() > 0 && prq[0].cyc <= cyc) begin
      p = prq.pop_front();
      n_vec++;
      if ((p.cyc != cyc) || (a !== p.a) || (c !== p.c) || (req_rdy !== p.rdy) ||
          (done !== 1'b0) || (err !== 1'b0) || (err_code !== 2'd0) ||
          (an_tag !== p.an) || (co_tag !== p.co) || (done_tag !== p.dt)) begin
        n_miss++;
        $display("FAIL probe: at cyc=%0d got a=%b c=%b rdy=%b done=%b err=%b code=%0d an=%0d co=%0d dt=%0d, required cyc=%0d a=%b c=%b rdy=%b an=%0d co=%0d dt=%0d quiet",
                 cyc, a, c, req_rdy, done, err, err_code, an_tag, co_tag, done_tag,
                 p.cyc, p.a, p.c, p.rdy, p.an, p.co, p.dt);
      end
    end
    if (fin) begin
      n_vec++;
      if (evq.size() != 0 || prq.size() != 0) begin
        n_miss++;
        $display("FAIL drain: %0d events and %0d probes outstanding, required 0 and 0",
                 evq.size(), prq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
    end
  end

  function automatic void push_probe(input int t, input logic aa, input logic cc, input logic rr,
                                     input logic [7:0] an, input logic [7:0] co, input logic [7:0] dt);
    pr_t p;
    p.cyc = t; p.a = aa; p.c = cc; p.rdy = rr; p.an = an; p.co = co; p.dt = dt;
    prq.push_back(p);
  endfunction

  // One transaction starting in an IDLE cycle. bm/dm bit k drives b/d on cycle k
  // of the grant window (ARM entry = 0) and completion window (CMD = 0).
  task automatic txn(input logic [15:0] bm, input logic [15:0] dm, input bit hold);
    int n, g, jd, jend, e, k, j;
    logic [7:0] an0, co0, dt0;
    ev_t ev;
    n = cyc;
    req = 1'b1;
    an0 = exp_an; co0 = exp_co; dt0 = exp_dt;
    g = -1;
    for (int i = 1; i <= B_MAX; i++) if (g < 0 && bm[i]) g = i;
    jd = -1;
    jend = D_MAX;
    if (g >= 0) begin
      for (int i = 0; i <= D_MAX; i++) if (jd < 0 && dm[i]) jd = i;
      if (jd >= 0) jend = jd;
    end
    ev.an = an0; ev.co = co0; ev.tag = 8'd0; ev.code = 2'd0; ev.is_err = 1'b1;
    if (g < 0) begin
      e = n + 2 + B_MAX;
      ev.code = 2'd1;
    end else begin
      e = n + 3 + g + jend;
      exp_an = an0 + 8'd1;
      exp_co = co0 + 8'd1;
      ev.an = exp_an;
      ev.co = exp_co;
      if (jd < 0)          ev.code = 2'd3;
      else if (jd < D_MIN) ev.code = 2'd2;
      else begin
        ev.is_err = 1'b0;
        ev.tag = co0;
        exp_dt = co0;
      end
    end
    ev.cyc = e;
    evq.push_back(ev);
    for (int t = n + 1; t <= e + 1; t++) begin
      @(posedge clk); #1;
      if (!hold || t > e) req = 1'b0;
      k = t - (n + 1);
      j = t - (n + 2 + g);
      b = (k < 16 && k <= ((g < 0) ? B_MAX : g)) ? bm[k] : 1'b0;
      d = (g >= 0 && j >= 0 && j <= jend) ? dm[j] : 1'b0;
      if (t == n + 1)                 push_probe(t, 1'b1, 1'b0, 1'b0, an0, co0, dt0);
      if (g >= 0 && t == n + 2 + g)   push_probe(t, 1'b0, 1'b1, 1'b0, exp_an, co0, dt0);
      if (t == e + 1)                 push_probe(t, 1'b0, 1'b0, 1'b1, exp_an, exp_co, exp_dt);
    end
    b = 1'b0;
    d = 1'b0;
  endtask

  // Grant, then reset two cycles into WAIT_D with d asserted on the reset cycle.
  task automatic rst_mid();
    req = 1'b1;
    @(posedge clk); #1; req = 1'b0; push_probe(cyc, 1'b1, 1'b0, 1'b0, exp_an, exp_co, exp_dt);
    @(posedge clk); #1; b = 1'b1;
    @(posedge clk); #1; b = 1'b0; push_probe(cyc, 1'b0, 1'b1, 1'b0, 8'(exp_an + 8'd1), exp_co, exp_dt);
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1; d = 1'b1;
    @(posedge clk); #1; rst = 1'b0; d = 1'b0;
    exp_an = 8'd0; exp_co = 8'd0; exp_dt = 8'd0;
    push_probe(cyc, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    @(posedge clk); #1; push_probe(cyc, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; b = 1'b0; d = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    push_probe(cyc, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    txn(16'h0000, 16'h0000, 1'b0);  // no grant: b timeout
    txn(16'h0008, 16'h0010, 1'b0);  // b at 3, d at 4: done tag 0
    txn(16'h0002, 16'h0002, 1'b0);  // d at 1: early
    txn(16'h0004, 16'h0000, 1'b0);  // no d: d timeout
    txn(16'h0021, 16'h0400, 1'b0);  // b at 0 ignored, grant at 5, d at D_MAX
    txn(16'h0002, 16'h0001, 1'b0);  // d during CMD: early
    txn(16'h0020, 16'h0004, 1'b1);  // d at D_MIN, req held while busy
    txn(16'h0001, 16'h0000, 1'b0);  // b only at cycle 0: timeout
    rst_mid();
    for (int i = 0; i < 256; i++) txn(16'h0002, 16'h0004, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    fin = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, required completion before 1000000 ns");
    $fatal(1);
  end

endmodule
